// File: rtl/draw_sequencer_if.sv
// Drawer-client and VGA plot bundle between draw_sequencer (master) and the
// drawers / VGA adapter side (slave).
interface draw_sequencer_if #(
    parameter int N_CLIENTS = 4
) ();
    logic [N_CLIENTS-1:0]   client_start;
    logic [N_CLIENTS-1:0]   client_done;
    logic [9*N_CLIENTS-1:0] client_x;
    logic [8*N_CLIENTS-1:0] client_y;
    logic [3*N_CLIENTS-1:0] client_colour;
    logic [N_CLIENTS-1:0]   client_plot;
    logic [8:0]             vga_x;
    logic [7:0]             vga_y;
    logic [2:0]             vga_colour;
    logic                   vga_plot;

    modport master (
        output client_start, vga_x, vga_y, vga_colour, vga_plot,
        input  client_done, client_x, client_y, client_colour, client_plot
    );

    modport slave (
        input  client_start, vga_x, vga_y, vga_colour, vga_plot,
        output client_done, client_x, client_y, client_colour, client_plot
    );
endinterface

// File: rtl/draw_sequencer.sv
// Runs enabled drawer clients one at a time over a level start/done handshake and
// forwards the active client's on-screen pixels as a registered plot stream.
module draw_sequencer #(
    parameter int N_CLIENTS = 4,
    parameter int TIMEOUT   = 200000,
    parameter int X_MAX     = 320,
    parameter int Y_MAX     = 240,
    localparam int IDX_W    = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic [N_CLIENTS-1:0] en_mask,
    draw_sequencer_if.master     bus,
    output logic [IDX_W-1:0]     cur_idx,
    output logic                 done,
    output logic                 timeout_err
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLIENTS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SELECT, ST_RUN, ST_RELEASE, ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_CLIENTS-1:0] mask_q, mask_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 terr_q, terr_d;
    logic [8:0]           vga_x_q, vga_x_d;
    logic [7:0]           vga_y_q, vga_y_d;
    logic [2:0]           vga_col_q, vga_col_d;
    logic                 vga_plot_q, vga_plot_d;

    logic [8:0] sel_x;
    logic [7:0] sel_y;
    logic [2:0] sel_col;
    logic       sel_plot;
    logic       sel_done;

    function automatic logic on_screen(input logic [8:0] x, input logic [7:0] y);
        return (int'(x) < X_MAX) && (int'(y) < Y_MAX);
    endfunction

    always_comb begin
        sel_x    = bus.client_x[9*idx_q +: 9];
        sel_y    = bus.client_y[8*idx_q +: 8];
        sel_col  = bus.client_colour[3*idx_q +: 3];
        sel_plot = bus.client_plot[idx_q];
        sel_done = bus.client_done[idx_q];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        timer_d = timer_q;
        terr_d  = terr_q;
        // Dropping req overrides every state, including a pending timeout.
        if (!req) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mask_d  = en_mask;
                    idx_d   = '0;
                    terr_d  = 1'b0;
                    state_d = ST_SELECT;
                end
                ST_SELECT: begin
                    if (mask_q[idx_q]) begin
                        timer_d = '0;
                        state_d = ST_RUN;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_RUN: begin
                    timer_d = timer_q + TMR_W'(1);
                    if (sel_done) begin
                        state_d = ST_RELEASE;
                    end else if (timer_q == TMR_LAST) begin
                        terr_d  = 1'b1;
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SELECT;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Pixel path: one register stage, coordinates hold between plots.
    always_comb begin
        vga_plot_d = req && (state_q == ST_RUN) && sel_plot && on_screen(sel_x, sel_y);
        vga_x_d    = vga_plot_d ? sel_x   : vga_x_q;
        vga_y_d    = vga_plot_d ? sel_y   : vga_y_q;
        vga_col_d  = vga_plot_d ? sel_col : vga_col_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            mask_q     <= '0;
            timer_q    <= '0;
            terr_q     <= 1'b0;
            vga_x_q    <= '0;
            vga_y_q    <= '0;
            vga_col_q  <= '0;
            vga_plot_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mask_q     <= mask_d;
            timer_q    <= timer_d;
            terr_q     <= terr_d;
            vga_x_q    <= vga_x_d;
            vga_y_q    <= vga_y_d;
            vga_col_q  <= vga_col_d;
            vga_plot_q <= vga_plot_d;
        end
    end

    always_comb begin
        bus.client_start = '0;
        if (state_q == ST_RUN) begin
            bus.client_start[idx_q] = 1'b1;
        end
    end

    assign done           = (state_q == ST_DONE);
    assign cur_idx        = idx_q;
    assign timeout_err    = terr_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_col_q;
    assign bus.vga_plot   = vga_plot_q;
endmodule

// File: tb/tb_draw_sequencer.sv
// Randomized bench for draw_sequencer: reactive drawer clients plus a frame-timeline
// reference built from per-client run lengths.
module tb_draw_sequencer;
    localparam int N     = 4;
    localparam int TO    = 16;
    localparam int NEVER = 1000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req = 1'b0;
    logic [N-1:0] en_mask = '0;
    logic [1:0]   cur_idx;
    logic         done;
    logic         timeout_err;

    draw_sequencer_if #(.N_CLIENTS(N)) bus ();

    draw_sequencer #(.N_CLIENTS(N), .TIMEOUT(TO), .X_MAX(320), .Y_MAX(240)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .en_mask(en_mask), .bus(bus.master),
        .cur_idx(cur_idx), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Drawer client scripts: pixel k is offered on the k-th cycle its start is high,
    // done is raised from step dlen onward.
    int         dlen [N];
    logic [8:0] px [N][16];
    logic [7:0] py [N][16];
    logic [2:0] pc [N][16];
    logic       pv [N][16];
    int         cnt [N];

    logic       exp_plot;
    logic [8:0] exp_x;
    logic [7:0] exp_y;
    logic [2:0] exp_c;

    typedef struct {
        logic [N-1:0] st;
        int           idx;
        logic         terr;
    } ent_t;
    ent_t seq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_vga();
        chk("vga_plot", 32'(bus.vga_plot), 32'(exp_plot));
        chk("vga_x", 32'(bus.vga_x), 32'(exp_x));
        chk("vga_y", 32'(bus.vga_y), 32'(exp_y));
        chk("vga_col", 32'(bus.vga_colour), 32'(exp_c));
    endtask

    // Drive client inputs for the coming edge; exp_st is the start vector the
    // timeline says is active this cycle.
    task automatic drive(input logic [N-1:0] exp_st);
        logic [9*N-1:0] vx;
        logic [8*N-1:0] vy;
        logic [3*N-1:0] vc;
        logic [N-1:0]   vp;
        logic [N-1:0]   vd;
        logic           nplot;
        logic [8:0]     x;
        logic [7:0]     y;
        logic [2:0]     c;
        logic           p;
        int             k;
        nplot = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.client_start[i]) begin
                k = cnt[i];
                x = px[i][(k < 16) ? k : 15];
                y = py[i][(k < 16) ? k : 15];
                c = pc[i][(k < 16) ? k : 15];
                p = (k < 16) ? pv[i][k] : 1'b0;
                vd[i] = (k >= dlen[i]);
                cnt[i] = cnt[i] + 1;
            end else begin
                cnt[i] = 0;
                x = 9'($urandom);
                y = 8'($urandom);
                c = 3'($urandom);
                p = 1'($urandom);
                vd[i] = 1'($urandom);
            end
            vx[9*i +: 9] = x;
            vy[8*i +: 8] = y;
            vc[3*i +: 3] = c;
            vp[i] = p;
            if (exp_st[i] && req && p && (x < 9'd320) && (y < 8'd240)) begin
                nplot = 1'b1;
                exp_x = x;
                exp_y = y;
                exp_c = c;
            end
        end
        exp_plot = nplot;
        bus.client_x      = vx;
        bus.client_y      = vy;
        bus.client_colour = vc;
        bus.client_plot   = vp;
        bus.client_done   = vd;
    endtask

    task automatic random_clients();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 16; k++) begin
                px[i][k] = 9'($urandom_range(0, 335));
                py[i][k] = 8'($urandom_range(0, 255));
                pc[i][k] = 3'($urandom);
                pv[i][k] = ($urandom_range(0, 3) != 0);
            end
            dlen[i] = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, 12);
        end
    endtask

    task automatic clear_clients();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 16; k++) begin
                px[i][k] = 9'(10 * i + k);
                py[i][k] = 8'(20 + k);
                pc[i][k] = 3'(i + k);
                pv[i][k] = 1'b0;
            end
            dlen[i] = 4;
        end
    endtask

    // mode 0: full frame, 1: drop req while client abort_client runs, 2: async reset
    // at timeline cycle abort_cyc.
    task automatic run_frame(input logic [N-1:0] mask, input int mode,
                             input int abort_client, input int abort_cyc);
        logic term;
        int   len;
        int   run;
        int   abort_at;
        term = 1'b0;
        seq.delete();
        for (int i = 0; i < N; i++) begin
            seq.push_back('{st: '0, idx: i, terr: term});
            if (mask[i]) begin
                run = (dlen[i] + 1 < TO) ? dlen[i] + 1 : TO;
                for (int r = 0; r < run; r++) seq.push_back('{st: N'(1 << i), idx: i, terr: term});
                if (dlen[i] >= TO) term = 1'b1;
                seq.push_back('{st: '0, idx: i, terr: term});
            end
        end
        len = seq.size();
        abort_at = -1;
        if (mode == 1) begin
            for (int c = len - 1; c >= 0; c--) if (seq[c].st[abort_client]) abort_at = c - 1;
            abort_at = abort_at + 3;
        end else if (mode == 2) begin
            abort_at = abort_cyc;
        end

        req = 1'b1;
        en_mask = mask;
        drive('0);
        for (int c = 0; c < len + 3; c++) begin
            step();
            if (c == 0) en_mask = N'($urandom);
            chk_vga();
            if (c < len) begin
                chk("start", 32'(bus.client_start), 32'(seq[c].st));
                chk("cur_idx", 32'(cur_idx), 32'(seq[c].idx));
                chk("done", 32'(done), 32'd0);
                chk("timeout_err", 32'(timeout_err), 32'(seq[c].terr));
            end else begin
                chk("start_done", 32'(bus.client_start), 32'd0);
                chk("cur_idx_done", 32'(cur_idx), 32'(N - 1));
                chk("done", 32'(done), 32'd1);
                chk("timeout_err_done", 32'(timeout_err), 32'(term));
            end
            if (c == abort_at && mode == 2) begin
                #3 rst_n = 1'b0;
                #1;
                chk("rst_start", 32'(bus.client_start), 32'd0);
                chk("rst_plot", 32'(bus.vga_plot), 32'd0);
                chk("rst_x", 32'(bus.vga_x), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_idx", 32'(cur_idx), 32'd0);
                chk("rst_terr", 32'(timeout_err), 32'd0);
                req = 1'b0;
                #2 rst_n = 1'b1;
                exp_plot = 1'b0; exp_x = '0; exp_y = '0; exp_c = '0;
                drive('0);
                step();
                chk_vga();
                chk("post_rst_start", 32'(bus.client_start), 32'd0);
                chk("post_rst_done", 32'(done), 32'd0);
                return;
            end
            if (c == abort_at && mode == 1) begin
                req = 1'b0;
                drive(seq[c].st);
                step();
                chk_vga();
                chk("abort_start", 32'(bus.client_start), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                drive('0);
                step();
                chk_vga();
                chk("abort_idle_start", 32'(bus.client_start), 32'd0);
                return;
            end
            drive((c < len) ? seq[c].st : N'(0));
        end
        req = 1'b0;
        drive('0);
        step();
        chk_vga();
        chk("release_done", 32'(done), 32'd0);
        chk("release_start", 32'(bus.client_start), 32'd0);
        drive('0);
        step();
        chk_vga();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_plot = 1'b0; exp_x = '0; exp_y = '0; exp_c = '0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        bus.client_x = '0; bus.client_y = '0; bus.client_colour = '0;
        bus.client_plot = '0; bus.client_done = '0;
        #2;
        chk("reset_start", 32'(bus.client_start), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_idx", 32'(cur_idx), 32'd0);
        chk("reset_terr", 32'(timeout_err), 32'd0);
        chk_vga();
        @(negedge clk);
        rst_n = 1'b1;
        drive('0);
        step();
        chk_vga();

        // T1: client0 three pixels, client2 two pixels
        clear_clients();
        for (int k = 0; k < 3; k++) pv[0][k] = 1'b1;
        for (int k = 0; k < 2; k++) pv[2][k] = 1'b1;
        dlen[0] = 3; dlen[2] = 2;
        run_frame(4'b0101, 0, 0, 0);

        // T2: empty mask
        random_clients();
        run_frame(4'b0000, 0, 0, 0);

        // T3: clipping on both axes, last pixel coincides with done
        clear_clients();
        px[1][0] = 9'd319; py[1][0] = 8'd239; pv[1][0] = 1'b1;
        px[1][1] = 9'd320; py[1][1] = 8'd10;  pv[1][1] = 1'b1;
        px[1][2] = 9'd5;   py[1][2] = 8'd240; pv[1][2] = 1'b1;
        px[1][3] = 9'd7;   py[1][3] = 8'd9;   pv[1][3] = 1'b1;
        dlen[1] = 3;
        run_frame(4'b0010, 0, 0, 0);

        // T4: client0 never finishes
        random_clients();
        dlen[0] = NEVER; dlen[1] = 4;
        run_frame(4'b0011, 0, 0, 0);

        // T5: req dropped mid-run of client1, then full restart
        random_clients();
        dlen[1] = 9;
        run_frame(4'b1111, 1, 1, 0);
        run_frame(4'b1111, 0, 0, 0);

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            random_clients();
            run_frame(N'($urandom), 0, 0, 0);
        end

        // T6: async reset mid-frame after a timeout was flagged
        random_clients();
        dlen[0] = NEVER;
        run_frame(4'b0001, 2, 0, TO + 3);
        random_clients();
        run_frame(4'b1010, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
